sddr_phy_data_scheduler: RTL and testbench
==========================================

Name: sddr_phy_data_scheduler

Overview:
- Parametrised data-path timing engine sitting between the controller and the PHY I/O primitives (ODDR/IDDR/IOBUF).
- Converts accepted read/write commands into cycle-exact DQ/DQS output-enable windows, write-clock gating and read-capture valid windows.
- Read latency and write latency are runtime-programmable; lane count and burst length are parametrised.
- Detects and rejects commands whose data windows would collide.

Parameters:
DATA_BITS, 16, DQ width; LANES = DATA_BITS/8
BURST_LEN, 8, DDR burst length in beats (even, ≥2); B = BURST_LEN/2 clocks per burst
MAX_LATENCY, 16, largest programmable read/write latency in clocks
LAT_BITS, $clog2(MAX_LATENCY+1), width of latency config ports

Ports:
in_ddr_clock_i  input  1  DDR-domain clock; all logic on rising edge
in_phy_reset_i  input  1  asynchronous, active-high reset
cfg_read_latency_i  input  LAT_BITS  RL in clocks (CL plus board/IDDR delay)
cfg_write_latency_i  input  LAT_BITS  WL in clocks (CWL)
ctl_cmd_valid_i  input  1  column command issued this cycle
ctl_cmd_write_i  input  1  1 = write, 0 = read; qualified by valid
ctl_cmd_error_o  output  1  one-cycle pulse: previous-cycle command rejected
ctl_busy_o  output  1  any data window pending or active
phy_dq_i  input  2×DATA_BITS  IDDR outputs [1:0] (rise, fall)
ctl_rd_data_o  output  2×DATA_BITS  registered read beats
ctl_rd_valid_o  output  1  ctl_rd_data_o holds a valid beat pair
phy_dq_oe_o  output  LANES  per-lane DQ drive enable (IOBUF T = !oe)
phy_dqs_oe_o  output  LANES  per-lane DQS drive enable incl. pre/postamble
phy_wr_clock_en_o  output  1  gated-clock enable for write ODDRs

Behaviour:
- Reset (async assert, sync-release assumed upstream): all schedule state cleared; every output 0, including ctl_rd_data_o. Reset mid-burst aborts the burst immediately; no window resumes after release.
- Latency clamp: values are sampled at command acceptance. Values <2 are treated as 2; values >MAX_LATENCY are treated as MAX_LATENCY. Config changes never affect already-scheduled commands.
- Scheduling: implemented as read and write shift-register timelines of depth MAX_LATENCY+B+2, advancing one position per clock.
- Command accepted at edge T (valid high):
  - Write: phy_dq_oe_o (all lanes) high cycles T+WL .. T+WL+B-1. phy_dqs_oe_o high T+WL-1 .. T+WL+B (one-clock preamble and postamble). phy_wr_clock_en_o equals the OR of the dqs window.
  - Read: capture window T+RL .. T+RL+B-1. ctl_rd_data_o <= phy_dq_i during that window. ctl_rd_valid_o high T+RL+1 .. T+RL+B (one-register latency). Outside the window, ctl_rd_data_o holds its last value.
- Same-type back-to-back: commands spaced exactly B clocks apart produce seamless windows. For writes, the shared pre/postamble cycle merges and DQS stays continuously enabled.
- Collision rule — the new command is rejected if any of the following hold:
  - (a) its core window overlaps a scheduled window of the same type;
  - (b) write dqs window [T+WL-1, T+WL+B] overlaps any read capture cycle widened by ±1 clock;
  - (c) read window [T+RL-1, T+RL+B] overlaps any scheduled write dqs cycle.
- On rejection: nothing is scheduled, and ctl_cmd_error_o pulses at T+1. Existing windows are unaffected.
- ctl_busy_o: high while any timeline bit is set or ctl_rd_valid_o is high. Combinationally independent of ctl_cmd_valid_i.
- All lanes are driven identically. The per-lane vectors exist to allow later per-lane deskew.

Test Plan:
- Reset release, no commands -> all outputs 0 for 50 clocks; busy 0.
- RL=6, read at T=10, phy_dq_i = incrementing pattern -> rd_valid high cycles 17..20 (B=4); data equals phy_dq_i sampled at 16..19; error 0.
- WL=5, writes at T=10 and T=14 -> dq_oe high 15..22 continuous; dqs_oe and wr_clock_en high 14..23; no error.
- WL=5, RL=6, write at T=10 then read at T=12 -> read rejected, error pulse at 13, write window unchanged. Repeat with read at T=15 -> accepted (window 21..24; read window guard 20..25 clears dqs window ending at 19).
- cfg_read_latency_i=0 and =31 -> treated as 2 and 16; change RL from 6 to 9 while a read is pending -> pending read keeps RL=6.
- Assert in_phy_reset_i mid-write (cycle T+WL+1) -> dq_oe, dqs_oe, busy drop to 0 asynchronously; after release, no residual window appears.

Source files
------------

// File: rtl/sddr_phy_data_scheduler_if.sv
// Signal bundle between the memory controller, the DQ/DQS data scheduler and
// the PHY I/O primitives. The controller/PHY side uses master, the scheduler slave.
interface sddr_phy_data_scheduler_if #(
    parameter int DATA_BITS = 16,
    parameter int LAT_BITS  = 5
);
    localparam int LANES = DATA_BITS / 8;

    logic [LAT_BITS-1:0]    cfg_read_latency_i;
    logic [LAT_BITS-1:0]    cfg_write_latency_i;
    logic                   ctl_cmd_valid_i;
    logic                   ctl_cmd_write_i;
    logic                   ctl_cmd_error_o;
    logic                   ctl_busy_o;
    logic [2*DATA_BITS-1:0] phy_dq_i;
    logic [2*DATA_BITS-1:0] ctl_rd_data_o;
    logic                   ctl_rd_valid_o;
    logic [LANES-1:0]       phy_dq_oe_o;
    logic [LANES-1:0]       phy_dqs_oe_o;
    logic                   phy_wr_clock_en_o;

    modport master (
        output cfg_read_latency_i, cfg_write_latency_i, ctl_cmd_valid_i,
               ctl_cmd_write_i, phy_dq_i,
        input  ctl_cmd_error_o, ctl_busy_o, ctl_rd_data_o, ctl_rd_valid_o,
               phy_dq_oe_o, phy_dqs_oe_o, phy_wr_clock_en_o
    );

    modport slave (
        input  cfg_read_latency_i, cfg_write_latency_i, ctl_cmd_valid_i,
               ctl_cmd_write_i, phy_dq_i,
        output ctl_cmd_error_o, ctl_busy_o, ctl_rd_data_o, ctl_rd_valid_o,
               phy_dq_oe_o, phy_dqs_oe_o, phy_wr_clock_en_o
    );
endinterface

// File: rtl/sddr_phy_data_scheduler.sv
// DQ/DQS data-path timing engine: turns accepted column commands into
// cycle-exact drive-enable, write-clock-gate and read-capture windows.
module sddr_phy_data_scheduler #(
    parameter int DATA_BITS   = 16,
    parameter int BURST_LEN   = 8,
    parameter int MAX_LATENCY = 16,
    parameter int LAT_BITS    = $clog2(MAX_LATENCY + 1)
) (
    input logic                     in_ddr_clock_i,
    input logic                     in_phy_reset_i,
    sddr_phy_data_scheduler_if.slave bus
);
    localparam int LANES = DATA_BITS / 8;
    localparam int B     = BURST_LEN / 2;
    localparam int DEPTH = MAX_LATENCY + B + 2;

    // Bit i of a mask set in cycle T refers to cycle T+i.
    localparam logic [DEPTH-1:0] CORE_MASK = {{(DEPTH - B){1'b0}}, {B{1'b1}}};
    localparam logic [DEPTH-1:0] EDGE_MASK = {{(DEPTH - B - 2){1'b0}}, {(B + 2){1'b1}}};

    logic [DEPTH-1:0]       rd_tl;
    logic [DEPTH-1:0]       wr_dq_tl;
    logic [DEPTH-1:0]       wr_dqs_tl;
    logic [2*DATA_BITS-1:0] rd_data_q;
    logic                   rd_valid_q;
    logic                   cmd_error_q;

    logic [LAT_BITS-1:0]    rl_eff;
    logic [LAT_BITS-1:0]    wl_eff;
    logic [DEPTH-1:0]       wr_core_new;
    logic [DEPTH-1:0]       wr_edge_new;
    logic [DEPTH-1:0]       rd_core_new;
    logic [DEPTH-1:0]       rd_guard_new;
    logic [DEPTH-1:0]       rd_widened;
    logic                   collide;
    logic                   accept_rd;
    logic                   accept_wr;

    function automatic logic [LAT_BITS-1:0] clamp_latency(input logic [LAT_BITS-1:0] cfg);
        if (cfg < LAT_BITS'(2))
            return LAT_BITS'(2);
        if (cfg > LAT_BITS'(MAX_LATENCY))
            return LAT_BITS'(MAX_LATENCY);
        return cfg;
    endfunction

    assign rl_eff = clamp_latency(bus.cfg_read_latency_i);
    assign wl_eff = clamp_latency(bus.cfg_write_latency_i);

    // Edge masks start one cycle early: DQS preamble for writes, turnaround guard for reads.
    assign wr_core_new  = CORE_MASK << wl_eff;
    assign wr_edge_new  = (EDGE_MASK << wl_eff) >> 1;
    assign rd_core_new  = CORE_MASK << rl_eff;
    assign rd_guard_new = (EDGE_MASK << rl_eff) >> 1;
    assign rd_widened   = rd_tl | (rd_tl << 1) | (rd_tl >> 1);

    always_comb begin
        collide = 1'b0;
        if (bus.ctl_cmd_write_i)
            collide = (|(wr_core_new & wr_dq_tl)) || (|(wr_edge_new & rd_widened));
        else
            collide = (|(rd_core_new & rd_tl)) || (|(rd_guard_new & wr_dqs_tl));
    end

    assign accept_wr = bus.ctl_cmd_valid_i &&  bus.ctl_cmd_write_i && !collide;
    assign accept_rd = bus.ctl_cmd_valid_i && !bus.ctl_cmd_write_i && !collide;

    // Timelines advance one slot per clock; bit 0 is the window state of the current cycle.
    always_ff @(posedge in_ddr_clock_i or posedge in_phy_reset_i) begin
        if (in_phy_reset_i) begin
            rd_tl       <= '0;
            wr_dq_tl    <= '0;
            wr_dqs_tl   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            rd_tl       <= (rd_tl     | (accept_rd ? rd_core_new : '0)) >> 1;
            wr_dq_tl    <= (wr_dq_tl  | (accept_wr ? wr_core_new : '0)) >> 1;
            wr_dqs_tl   <= (wr_dqs_tl | (accept_wr ? wr_edge_new : '0)) >> 1;
            rd_valid_q  <= rd_tl[0];
            cmd_error_q <= bus.ctl_cmd_valid_i && collide;
            if (rd_tl[0])
                rd_data_q <= bus.phy_dq_i;
        end
    end

    assign bus.ctl_rd_data_o     = rd_data_q;
    assign bus.ctl_rd_valid_o    = rd_valid_q;
    assign bus.ctl_cmd_error_o   = cmd_error_q;
    assign bus.ctl_busy_o        = (|rd_tl) || (|wr_dq_tl) || (|wr_dqs_tl) || rd_valid_q;
    assign bus.phy_dq_oe_o       = {LANES{wr_dq_tl[0]}};
    assign bus.phy_dqs_oe_o      = {LANES{wr_dqs_tl[0]}};
    assign bus.phy_wr_clock_en_o = wr_dqs_tl[0];
endmodule

// File: tb/tb_sddr_phy_data_scheduler.sv
// Scoreboard bench for sddr_phy_data_scheduler: directed commands push expected
// windows and read beats; a negedge monitor compares what the DUT presents.
module tb_sddr_phy_data_scheduler;
    localparam int DATA_BITS   = 16;
    localparam int BURST_LEN   = 8;
    localparam int MAX_LATENCY = 16;
    localparam int LAT_BITS    = 5;
    localparam int LANES       = DATA_BITS / 8;
    localparam int B           = BURST_LEN / 2;
    localparam int MAP_LEN     = 512;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_beat_t;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    int       cyc;
    int       checks = 0;
    int       errors = 0;
    bit       mon_en = 1'b0;
    rd_beat_t rd_q[$];
    int       err_q[$];
    bit       exp_dq[MAP_LEN];
    bit       exp_dqs[MAP_LEN];
    bit       exp_busy[MAP_LEN];

    sddr_phy_data_scheduler_if #(.DATA_BITS(DATA_BITS), .LAT_BITS(LAT_BITS)) bus ();

    sddr_phy_data_scheduler #(
        .DATA_BITS  (DATA_BITS),
        .BURST_LEN  (BURST_LEN),
        .MAX_LATENCY(MAX_LATENCY),
        .LAT_BITS   (LAT_BITS)
    ) dut (
        .in_ddr_clock_i(clk),
        .in_phy_reset_i(rst),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    // Cycle index restarts with every reset so test vectors use plan-relative numbers.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [31:0] pattern(input int c);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = 16'(c) + 16'h0100;
        lo = 16'hF000 - 16'(c);
        return {hi, lo};
    endfunction

    always @(negedge clk) bus.phy_dq_i = pattern(cyc);

    task automatic checkValue(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [LANES-1:0] want_dq;
        logic [LANES-1:0] want_dqs;
        bit               want_busy;
        rd_beat_t         beat;
        int               ecyc;
        want_dq   = '0;
        want_dqs  = '0;
        want_busy = 1'b0;
        if (cyc < MAP_LEN) begin
            want_dq   = exp_dq[cyc]  ? '1 : '0;
            want_dqs  = exp_dqs[cyc] ? '1 : '0;
            want_busy = exp_busy[cyc];
        end
        checkValue("dq_oe",     64'(bus.phy_dq_oe_o),       64'(want_dq));
        checkValue("dqs_oe",    64'(bus.phy_dqs_oe_o),      64'(want_dqs));
        checkValue("wr_clk_en", 64'(bus.phy_wr_clock_en_o), 64'(want_dqs[0]));
        checkValue("busy",      64'(bus.ctl_busy_o),        64'(want_busy));
        if (bus.ctl_rd_valid_o) begin
            if (rd_q.size() == 0) begin
                checkValue("rd_valid_extra", 64'(bus.ctl_rd_valid_o), 64'(0));
            end else begin
                beat = rd_q.pop_front();
                checkValue("rd_beat_cycle", 64'(cyc), 64'(beat.cyc));
                checkValue("rd_data", 64'(bus.ctl_rd_data_o), 64'(beat.data));
            end
        end
        if (bus.ctl_cmd_error_o) begin
            if (err_q.size() == 0) begin
                checkValue("error_extra", 64'(bus.ctl_cmd_error_o), 64'(0));
            end else begin
                ecyc = err_q.pop_front();
                checkValue("error_cycle", 64'(cyc), 64'(ecyc));
            end
        end
    endtask

    always @(negedge clk) if (mon_en) checkOutput();

    task automatic waitCycle(input int t);
        int budget;
        budget = 0;
        while (cyc < t && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (cyc != t) checkValue("wait_cycle", 64'(cyc), 64'(t));
    endtask

    task automatic mark(input int kind, input int first, input int last);
        for (int c = first; c <= last; c++) begin
            if (c >= 0 && c < MAP_LEN) begin
                if (kind == 0) exp_dq[c]   = 1'b1;
                if (kind == 1) exp_dqs[c]  = 1'b1;
                if (kind == 2) exp_busy[c] = 1'b1;
            end
        end
    endtask

    // Issue one command during cycle t; lat_eff is the hand-clamped latency it should use.
    task automatic applyStimulus(input int t, input bit wr, input int rl_cfg, input int wl_cfg,
                                 input bit accept, input int lat_eff);
        waitCycle(t);
        bus.cfg_read_latency_i  = LAT_BITS'(rl_cfg);
        bus.cfg_write_latency_i = LAT_BITS'(wl_cfg);
        bus.ctl_cmd_write_i     = wr;
        bus.ctl_cmd_valid_i     = 1'b1;
        if (!accept) begin
            err_q.push_back(t + 1);
        end else if (wr) begin
            mark(0, t + lat_eff,     t + lat_eff + B - 1);
            mark(1, t + lat_eff - 1, t + lat_eff + B);
            mark(2, t + 1,           t + lat_eff + B);
        end else begin
            for (int k = 0; k < B; k++) begin
                rd_beat_t beat;
                beat.cyc  = t + lat_eff + 1 + k;
                beat.data = pattern(t + lat_eff + k);
                rd_q.push_back(beat);
            end
            mark(2, t + 1, t + lat_eff + B);
        end
        @(negedge clk);
        bus.ctl_cmd_valid_i = 1'b0;
    endtask

    task automatic setCfg(input int t, input int rl_cfg, input int wl_cfg);
        waitCycle(t);
        bus.cfg_read_latency_i  = LAT_BITS'(rl_cfg);
        bus.cfg_write_latency_i = LAT_BITS'(wl_cfg);
    endtask

    task automatic checkDrained();
        checkValue("rd_beats_missing", 64'(rd_q.size()),  64'(0));
        checkValue("errors_missing",   64'(err_q.size()), 64'(0));
    endtask

    task automatic resetAndCheck();
        mon_en = 1'b0;
        rst    = 1'b1;
        bus.ctl_cmd_valid_i = 1'b0;
        #1;
        checkValue("rst_rd_data",  64'(bus.ctl_rd_data_o),     64'(0));
        checkValue("rst_rd_valid", 64'(bus.ctl_rd_valid_o),    64'(0));
        checkValue("rst_error",    64'(bus.ctl_cmd_error_o),   64'(0));
        checkValue("rst_busy",     64'(bus.ctl_busy_o),        64'(0));
        checkValue("rst_dq_oe",    64'(bus.phy_dq_oe_o),       64'(0));
        checkValue("rst_dqs_oe",   64'(bus.phy_dqs_oe_o),      64'(0));
        checkValue("rst_wr_clk",   64'(bus.phy_wr_clock_en_o), 64'(0));
        for (int c = 0; c < MAP_LEN; c++) begin
            exp_dq[c]   = 1'b0;
            exp_dqs[c]  = 1'b0;
            exp_busy[c] = 1'b0;
        end
        rd_q.delete();
        err_q.delete();
    endtask

    task automatic releaseReset();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        resetAndCheck();
        releaseReset();
    endtask

    initial begin
        bus.cfg_read_latency_i  = '0;
        bus.cfg_write_latency_i = '0;
        bus.ctl_cmd_valid_i     = 1'b0;
        bus.ctl_cmd_write_i     = 1'b0;

        $display("[TB] idle after reset");
        doReset();
        waitCycle(50);
        checkDrained();

        $display("[TB] single read RL=6");
        doReset();
        applyStimulus(10, 1'b0, 6, 5, 1'b1, 6);
        waitCycle(30);
        checkDrained();

        $display("[TB] back-to-back writes WL=5");
        doReset();
        applyStimulus(10, 1'b1, 6, 5, 1'b1, 5);
        applyStimulus(14, 1'b1, 6, 5, 1'b1, 5);
        waitCycle(40);
        checkDrained();

        $display("[TB] turnaround and same-type collisions");
        doReset();
        applyStimulus(10, 1'b1, 6, 5, 1'b1, 5);
        applyStimulus(12, 1'b0, 6, 5, 1'b0, 6);
        applyStimulus(15, 1'b0, 6, 5, 1'b1, 6);
        applyStimulus(17, 1'b0, 6, 5, 1'b0, 6);
        applyStimulus(20, 1'b1, 6, 5, 1'b0, 5);
        waitCycle(45);
        checkDrained();

        $display("[TB] latency clamp and config change while pending");
        doReset();
        applyStimulus(10, 1'b0, 0,  5, 1'b1, 2);
        applyStimulus(20, 1'b0, 31, 5, 1'b1, 16);
        applyStimulus(50, 1'b1, 6,  0, 1'b1, 2);
        applyStimulus(60, 1'b0, 6,  5, 1'b1, 6);
        setCfg(62, 9, 5);
        applyStimulus(70, 1'b0, 9,  5, 1'b1, 9);
        waitCycle(90);
        checkDrained();

        $display("[TB] reset mid-write");
        doReset();
        applyStimulus(10, 1'b1, 6, 5, 1'b1, 5);
        waitCycle(16);
        #2;
        resetAndCheck();
        releaseReset();
        waitCycle(40);
        checkDrained();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end
endmodule
